bf4_sdf: RTL and testbench
==========================

# bf4_sdf

Radix-2 single-delay-feedback butterfly for the 4th FFT stage of the 32-point pipeline. It sits directly downstream of the stage-4 control unit and consumes that unit's registered sample, phase (`state`) and 2-bit twiddle code (`WN`). It owns the 4-deep complex feedback delay line, the add/subtract butterfly and the trivial ±1/±j rotation. Its registered output feeds the next stage.

## Interface
Parameters:
- `IW`, 15: input sample width per component (signed).
- `OW`, 16: output and delay-line width per component (signed, IW+1).
- `DEPTH`, 4: feedback delay length, N/2 for this stage.

Ports:
- `clk`, in, 1: clock; all state updates on the rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `valid_i`, in, 1: the controller's block-valid flag.
- `state`, in, 2: controller phase: 00 IDLE, 01 FIRST, 10 SECOND, 11 WAITING.
- `WN`, in, 2: twiddle code n for exp(-j2πn/4): 00→1, 01→−j, 10→−1, 11→+j.
- `data_in_r`, `data_in_i`, in, IW each: sample A, already aligned with `state` and `WN`.
- `valid_o`, out, 1: output sample valid.
- `data_out_r`, `data_out_i`, out, OW each: butterfly result.
- `idx_o`, out, 3: position of the current output within its 8-sample block (0..7).

## Operation
- Delay line: DEPTH complex OW-bit entries. H is the head (oldest entry). On every cycle that is not IDLE, the line shifts: H leaves and a new entry enters at the tail.
- Behaviour by state (A = input sign-extended to OW):
  - IDLE: the line holds. The output stage loads 0 and `valid_o` is 0.
  - WAITING: the line shifts in A. `valid_o` is 0.
  - FIRST: output is H + A. The line shifts in H − A.
  - SECOND: output is rot(WN, H). The line shifts in A, which pre-fills the next block.
- Rotation of (r,i):
  - 00 gives (r,i).
  - 01 gives (i,−r).
  - 10 gives (−r,−i).
  - 11 gives (−i,r).
  - Width rules: H − A always lies within ±(2^(IW)−1), so negation never overflows. The sum H + A is exact in OW bits. No rounding and no saturation are applied.
- `valid_o` is registered as `valid_i` AND (state == FIRST or state == SECOND).
- `idx_o` increments on each valid output and wraps 7→0. It is forced to 0 on any cycle where the registered valid is 0.
- Back-to-back blocks: when SECOND is followed directly by FIRST, there is no bubble and `idx_o` wraps to 0 on schedule.
- Illegal combinations:
  - `valid_i` = 1 in IDLE is ignored; the controller leaves IDLE itself.
  - `WN` ≠ 00 during FIRST has no effect.

## Timing
- Latency is 1 cycle: the inputs present in cycle t appear on `data_out_*`, `valid_o` and `idx_o` at t+1.
- The delay line is written in the same edge as the output register.
- Reset values: `valid_o` = 0, `data_out_r` = `data_out_i` = 0, `idx_o` = 0, all delay-line entries 0.
- Reset takes effect immediately, without waiting for a clock edge.
- Reset mid-block: the partial block is discarded. The first block after release must produce correct results only once WAITING has refilled all DEPTH entries; the controller guarantees this.
- Steady-state throughput is one sample per cycle.

## Structure
- Shared package `fft_pkg` holds:
  - the state encodings IDLE/FIRST/SECOND/WAITING, shared with the controller;
  - the WN codes ZERO..THREE;
  - the widths IW and OW.
- Sub-module `tw4_rot` is the purely combinational ±1/±j rotator (OW in, OW out, 2-bit code).
- The delay line, butterfly and output register stay in `bf4_sdf`.

## Test plan
- Reset: assert `rst` mid-stream. `valid_o`, `data_out_*` and `idx_o` must go to 0 immediately, and after release the outputs stay 0 while the state is IDLE.
- Single block, real ramp: x0..x7 = 1..8 with imaginary parts 0.
  - FIRST outputs (6,0), (8,0), (10,0), (12,0) with `idx_o` 0..3.
  - SECOND outputs (−4,0), (0,4), (4,0), (0,−4) with `idx_o` 4..7.
  - `valid_o` then drops.
- Imaginary path: x0..x3 = (0,3), x4..x7 = (0,1).
  - FIRST outputs (0,4) four times.
  - SECOND outputs (0,2), (2,0), (0,−2), (−2,0).
- Extremes: x0..x3 = (16383,−16384) and x4..x7 = (−16384,16383).
  - FIRST outputs (−1,−1).
  - SECOND outputs (32767,−32767), (−32767,−32767), (−32767,32767), (32767,32767), with no wrap.
- Back-to-back: two ramp blocks with no gap. The second block's FIRST must directly follow the first block's SECOND, give the same results as the single-block test, and `idx_o` must wrap 7→0 with `valid_o` held high throughout.

Source files
------------

// File: rtl/fft_pkg.sv
// -----------------------------------------------------------------------------
// fft_pkg
// Definitions shared by the 32-point FFT pipeline stages and their controllers.
//   - Sample widths: IW for samples entering a stage, OW for the stage output
//     and its feedback delay line.
//   - Controller phase encodings, which must agree with the stage controller.
//   - Trivial twiddle codes n for exp(-j*2*pi*n/4).
// No ports: this is a package.
// -----------------------------------------------------------------------------
package fft_pkg;

    // Sample widths per real/imaginary component. The delay line and the
    // output carry one extra bit so the butterfly sum and difference are exact.
    localparam int IW = 15;
    localparam int OW = IW + 1;

    // Controller phase. Shared with the stage-4 controller, so the encoding
    // is fixed.
    localparam logic [1:0] IDLE    = 2'b00;
    localparam logic [1:0] FIRST   = 2'b01;
    localparam logic [1:0] SECOND  = 2'b10;
    localparam logic [1:0] WAITING = 2'b11;

    // Twiddle codes: ZERO -> 1, ONE -> -j, TWO -> -1, THREE -> +j.
    localparam logic [1:0] ZERO  = 2'b00;
    localparam logic [1:0] ONE   = 2'b01;
    localparam logic [1:0] TWO   = 2'b10;
    localparam logic [1:0] THREE = 2'b11;

endpackage

// File: rtl/tw4_rot.sv
// -----------------------------------------------------------------------------
// tw4_rot
// Purely combinational multiply of a complex sample by one of the trivial
// twiddles 1, -j, -1 and +j. Only swaps and negations are needed, so no
// multiplier is inferred.
// Ports:
//   wn           in  2   twiddle code (ZERO..THREE from fft_pkg)
//   in_r, in_i   in  OW  complex operand, signed
//   out_r, out_i out OW  rotated result, signed
// The caller guarantees that the operand is never the most negative OW-bit
// value, so the negations cannot overflow.
// -----------------------------------------------------------------------------
module tw4_rot #(
    parameter int OW = fft_pkg::OW
) (
    input  logic [1:0]           wn,
    input  logic signed [OW-1:0] in_r,
    input  logic signed [OW-1:0] in_i,
    output logic signed [OW-1:0] out_r,
    output logic signed [OW-1:0] out_i
);

    import fft_pkg::*;

    // (r + j i) times 1, -j, -1 or +j:
    //   -j gives ( i, -r), -1 gives (-r, -i), +j gives (-i,  r).
    always_comb begin
        out_r = in_r;
        out_i = in_i;
        case (wn)
            ONE: begin
                out_r = in_i;
                out_i = -in_r;
            end
            TWO: begin
                out_r = -in_r;
                out_i = -in_i;
            end
            THREE: begin
                out_r = -in_i;
                out_i = in_r;
            end
            default: begin
                out_r = in_r;
                out_i = in_i;
            end
        endcase
    end

endmodule

// File: rtl/bf4_sdf.sv
// -----------------------------------------------------------------------------
// bf4_sdf
// Radix-2 single-delay-feedback butterfly for the 4th stage of the 32-point
// FFT pipeline. It follows the stage-4 controller, which supplies the phase,
// the twiddle code and the sample already aligned with each other.
//
// Per block of 8 samples x0..x7 the controller runs:
//   WAITING x4 : x0..x3 are loaded into the feedback line
//   FIRST   x4 : output x(k) + x(k+4); the line stores x(k) - x(k+4)
//   SECOND  x4 : output (x(k) - x(k+4)) * W(k); the line stores the incoming
//                sample, which is x0..x3 of the next block when blocks run
//                back to back
// IDLE freezes the line and clears the output register.
//
// Ports:
//   clk                    in  1   rising-edge clock
//   rst                    in  1   asynchronous active-high reset
//   valid_i                in  1   controller block-valid flag
//   state                  in  2   controller phase (IDLE/FIRST/SECOND/WAITING)
//   WN                     in  2   twiddle code used during SECOND
//   data_in_r, data_in_i   in  IW  input sample, signed
//   valid_o                out 1   output sample valid
//   data_out_r, data_out_i out OW  butterfly result, signed
//   idx_o                  out 3   position of the output within its block
// All outputs are registered; latency is one cycle.
// -----------------------------------------------------------------------------
module bf4_sdf #(
    parameter int IW    = fft_pkg::IW,
    parameter int OW    = fft_pkg::OW,
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid_i,
    input  logic [1:0]           state,
    input  logic [1:0]           WN,
    input  logic signed [IW-1:0] data_in_r,
    input  logic signed [IW-1:0] data_in_i,
    output logic                 valid_o,
    output logic signed [OW-1:0] data_out_r,
    output logic signed [OW-1:0] data_out_i,
    output logic [2:0]           idx_o
);

    import fft_pkg::*;

    // Feedback delay line; entry 0 is the head (oldest sample).
    logic signed [OW-1:0] dl_r [DEPTH];
    logic signed [OW-1:0] dl_i [DEPTH];

    logic signed [OW-1:0] a_r;
    logic signed [OW-1:0] a_i;
    logic signed [OW-1:0] head_r;
    logic signed [OW-1:0] head_i;
    logic signed [OW-1:0] sum_r;
    logic signed [OW-1:0] sum_i;
    logic signed [OW-1:0] diff_r;
    logic signed [OW-1:0] diff_i;
    logic signed [OW-1:0] rot_r;
    logic signed [OW-1:0] rot_i;

    logic signed [OW-1:0] tail_r;
    logic signed [OW-1:0] tail_i;
    logic signed [OW-1:0] out_next_r;
    logic signed [OW-1:0] out_next_i;
    logic                 valid_next;
    logic                 shift_en;

    // Sign-extend the input to the delay-line width so the sum and difference
    // with the head are exact.
    assign a_r = {{(OW-IW){data_in_r[IW-1]}}, data_in_r};
    assign a_i = {{(OW-IW){data_in_i[IW-1]}}, data_in_i};

    assign head_r = dl_r[0];
    assign head_i = dl_i[0];

    assign sum_r  = head_r + a_r;
    assign sum_i  = head_i + a_i;
    assign diff_r = head_r - a_r;
    assign diff_i = head_i - a_i;

    // The head only reaches the rotator during SECOND, when it holds a
    // difference of two IW-bit samples, so it is never the most negative
    // OW-bit value.
    tw4_rot #(
        .OW    (OW)
    ) u_rot (
        .wn    (WN),
        .in_r  (head_r),
        .in_i  (head_i),
        .out_r (rot_r),
        .out_i (rot_i)
    );

    // Phase decode: choose what enters the tail of the line and what the
    // output register captures. WAITING and SECOND both load the raw sample;
    // only FIRST feeds back the difference. WN is ignored outside SECOND.
    always_comb begin
        tail_r     = a_r;
        tail_i     = a_i;
        out_next_r = '0;
        out_next_i = '0;
        valid_next = 1'b0;
        case (state)
            FIRST: begin
                tail_r     = diff_r;
                tail_i     = diff_i;
                out_next_r = sum_r;
                out_next_i = sum_i;
                valid_next = valid_i;
            end
            SECOND: begin
                out_next_r = rot_r;
                out_next_i = rot_i;
                valid_next = valid_i;
            end
            default: begin
                out_next_r = '0;
                out_next_i = '0;
                valid_next = 1'b0;
            end
        endcase
    end

    // The line advances on every non-IDLE cycle, whether or not the
    // controller flags the block valid, so it stays in step with the phase.
    assign shift_en = (state != IDLE);

    // Feedback delay line: shift towards the head and insert at the tail.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                dl_r[k] <= '0;
                dl_i[k] <= '0;
            end
        end else if (shift_en) begin
            for (int k = 0; k < DEPTH - 1; k++) begin
                dl_r[k] <= dl_r[k + 1];
                dl_i[k] <= dl_i[k + 1];
            end
            dl_r[DEPTH - 1] <= tail_r;
            dl_i[DEPTH - 1] <= tail_i;
        end
    end

    // Output register. The index counts consecutive valid outputs and wraps
    // naturally at 8; any invalid cycle restarts it at 0, so a block that
    // follows a gap always begins at index 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_o    <= 1'b0;
            data_out_r <= '0;
            data_out_i <= '0;
            idx_o      <= 3'd0;
        end else begin
            valid_o    <= valid_next;
            data_out_r <= out_next_r;
            data_out_i <= out_next_i;
            if (valid_next && valid_o) begin
                idx_o <= idx_o + 3'd1;
            end else begin
                idx_o <= 3'd0;
            end
        end
    end

endmodule

// File: tb/tb_bf4_sdf.sv
// -----------------------------------------------------------------------------
// tb_bf4_sdf
// Self-checking bench for bf4_sdf: a table of directed vectors taken from the
// block-level butterfly results, a hand-written asynchronous reset sequence,
// and randomized controller-like traffic checked against a queue-based
// complex-arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_bf4_sdf;

    import fft_pkg::*;

    localparam int TB_IW = 15;
    localparam int TB_OW = 16;

    logic                    clk;
    logic                    rst;
    logic                    valid_i;
    logic [1:0]              state;
    logic [1:0]              WN;
    logic signed [TB_IW-1:0] data_in_r;
    logic signed [TB_IW-1:0] data_in_i;
    logic                    valid_o;
    logic signed [TB_OW-1:0] data_out_r;
    logic signed [TB_OW-1:0] data_out_i;
    logic [2:0]              idx_o;

    int tests_run;
    int tests_failed;

    typedef struct {
        logic [1:0] st;
        logic [1:0] wn;
        int         ar;
        int         ai;
        logic       vin;
        logic       ev;
        int         er;
        int         ei;
        int         eidx;
        logic       cd;
    } vec_t;

    vec_t tbl[$];

    // Reference model state: delay line as a queue of complex values plus the
    // length of the current run of valid outputs.
    int mq_r[$];
    int mq_i[$];
    int run_len;

    bf4_sdf #(
        .IW         (TB_IW),
        .OW         (TB_OW),
        .DEPTH      (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .valid_i    (valid_i),
        .state      (state),
        .WN         (WN),
        .data_in_r  (data_in_r),
        .data_in_i  (data_in_i),
        .valid_o    (valid_o),
        .data_out_r (data_out_r),
        .data_out_i (data_out_i),
        .idx_o      (idx_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs, then sample just after the capturing edge.
    task automatic applyStimulus(input vec_t v);
        valid_i   = v.vin;
        state     = v.st;
        WN        = v.wn;
        data_in_r = TB_IW'(v.ar);
        data_in_i = TB_IW'(v.ai);
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic ev, input int er,
                               input int ei, input int eidx, input logic cd);
        tests_run++;
        if (valid_o !== ev) begin
            tests_failed++;
            $display("[TB] FAIL %s valid_o: got %0b expected %0b", name, valid_o, ev);
        end
        tests_run++;
        if (int'(idx_o) != eidx) begin
            tests_failed++;
            $display("[TB] FAIL %s idx_o: got %0d expected %0d", name, idx_o, eidx);
        end
        if (cd) begin
            tests_run++;
            if (int'(data_out_r) != er || int'(data_out_i) != ei) begin
                tests_failed++;
                $display("[TB] FAIL %s data: got (%0d,%0d) expected (%0d,%0d)",
                         name, data_out_r, data_out_i, er, ei);
            end
        end
    endtask

    function automatic void addVec(input logic [1:0] st, input logic [1:0] wn,
                                   input int ar, input int ai, input logic vin,
                                   input logic ev, input int er, input int ei,
                                   input int eidx, input logic cd);
        vec_t v;
        v.st = st; v.wn = wn; v.ar = ar; v.ai = ai; v.vin = vin;
        v.ev = ev; v.er = er; v.ei = ei; v.eidx = eidx; v.cd = cd;
        tbl.push_back(v);
    endfunction

    function automatic void addWaiting(input int lr[4], input int li[4]);
        for (int k = 0; k < 4; k++)
            addVec(WAITING, ZERO, lr[k], li[k], 1'b1, 1'b0, 0, 0, 0, 1'b0);
    endfunction

    // Non-zero WN codes in FIRST must not disturb the result.
    function automatic void addFirst(input int hr[4], input int hi[4],
                                     input int fr[4], input int fi[4]);
        for (int k = 0; k < 4; k++)
            addVec(FIRST, 2'(3 - k), hr[k], hi[k], 1'b1, 1'b1, fr[k], fi[k], k, 1'b1);
    endfunction

    function automatic void addSecond(input int pr[4], input int pi[4],
                                      input int sr[4], input int si[4]);
        for (int k = 0; k < 4; k++)
            addVec(SECOND, 2'(k), pr[k], pi[k], 1'b1, 1'b1, sr[k], si[k], 4 + k, 1'b1);
    endfunction

    function automatic void addIdle();
        addVec(IDLE, ZERO, 0, 0, 1'b1, 1'b0, 0, 0, 0, 1'b1);
    endfunction

    // One cycle of the reference model: returns what the DUT must show after
    // the edge that captures these inputs.
    task automatic modelStep(input logic [1:0] st, input logic [1:0] wn,
                             input logic vin, input int ar, input int ai,
                             output logic ev, output int er, output int ei,
                             output int eidx);
        int hr, hi, c, s;
        er = 0;
        ei = 0;
        ev = vin && (st == FIRST || st == SECOND);
        if (st != IDLE) begin
            hr = mq_r.pop_front();
            hi = mq_i.pop_front();
            if (st == FIRST) begin
                er = hr + ar;
                ei = hi + ai;
                mq_r.push_back(hr - ar);
                mq_i.push_back(hi - ai);
            end else begin
                if (st == SECOND) begin
                    // W = cos + j sin of -2*pi*n/4
                    c = (wn == 2'd0) ? 1 : (wn == 2'd2) ? -1 : 0;
                    s = (wn == 2'd1) ? -1 : (wn == 2'd3) ? 1 : 0;
                    er = hr * c - hi * s;
                    ei = hr * s + hi * c;
                end
                mq_r.push_back(ar);
                mq_i.push_back(ai);
            end
        end
        if (ev) begin
            eidx = run_len % 8;
            run_len++;
        end else begin
            eidx = 0;
            run_len = 0;
        end
    endtask

    task automatic randStep(input logic [1:0] st, input logic [1:0] wn, input int n);
        vec_t v;
        logic ev;
        int er, ei, eidx;
        v.st  = st;
        v.wn  = wn;
        v.vin = ($urandom_range(9) != 0);
        v.ar  = int'($urandom_range(32767)) - 16384;
        v.ai  = int'($urandom_range(32767)) - 16384;
        modelStep(v.st, v.wn, v.vin, v.ar, v.ai, ev, er, ei, eidx);
        applyStimulus(v);
        checkOutput($sformatf("rand%0d", n), ev, er, ei, eidx, st != WAITING);
    endtask

    task automatic resetDut();
        rst = 1'b1;
        valid_i = 1'b0;
        state = IDLE;
        WN = ZERO;
        data_in_r = '0;
        data_in_i = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        mq_r.delete();
        mq_i.delete();
        for (int k = 0; k < 4; k++) begin
            mq_r.push_back(0);
            mq_i.push_back(0);
        end
        run_len = 0;
    endtask

    int ramp_lo_r[4], ramp_hi_r[4], zeros[4];
    int ramp_f_r[4], ramp_s_r[4], ramp_s_i[4];
    int im_lo_i[4], im_hi_i[4], im_f_i[4], im_s_r[4], im_s_i[4];
    int ex_lo_r[4], ex_lo_i[4], ex_hi_r[4], ex_hi_i[4];
    int ex_f[4], ex_s_r[4], ex_s_i[4];

    initial begin
        vec_t v;
        int n;
        bit prefilled;

        tests_run    = 0;
        tests_failed = 0;

        zeros     = '{0, 0, 0, 0};
        ramp_lo_r = '{1, 2, 3, 4};
        ramp_hi_r = '{5, 6, 7, 8};
        ramp_f_r  = '{6, 8, 10, 12};
        ramp_s_r  = '{-4, 0, 4, 0};
        ramp_s_i  = '{0, 4, 0, -4};
        im_lo_i   = '{3, 3, 3, 3};
        im_hi_i   = '{1, 1, 1, 1};
        im_f_i    = '{4, 4, 4, 4};
        im_s_r    = '{0, 2, 0, -2};
        im_s_i    = '{2, 0, -2, 0};
        ex_lo_r   = '{16383, 16383, 16383, 16383};
        ex_lo_i   = '{-16384, -16384, -16384, -16384};
        ex_hi_r   = '{-16384, -16384, -16384, -16384};
        ex_hi_i   = '{16383, 16383, 16383, 16383};
        ex_f      = '{-1, -1, -1, -1};
        ex_s_r    = '{32767, -32767, -32767, 32767};
        ex_s_i    = '{-32767, -32767, 32767, 32767};

        // Idle after reset, with valid_i raised to show it is ignored.
        addIdle();
        addIdle();
        // Real ramp.
        addWaiting(ramp_lo_r, zeros);
        addFirst(ramp_hi_r, zeros, ramp_f_r, zeros);
        addSecond(zeros, zeros, ramp_s_r, ramp_s_i);
        addIdle();
        // Imaginary path.
        addWaiting(zeros, im_lo_i);
        addFirst(zeros, im_hi_i, zeros, im_f_i);
        addSecond(zeros, zeros, im_s_r, im_s_i);
        addIdle();
        // Extremes.
        addWaiting(ex_lo_r, ex_lo_i);
        addFirst(ex_hi_r, ex_hi_i, ex_f, ex_f);
        addSecond(zeros, zeros, ex_s_r, ex_s_i);
        addIdle();
        // Back to back: SECOND prefills the next block, FIRST follows directly.
        addWaiting(ramp_lo_r, zeros);
        addFirst(ramp_hi_r, zeros, ramp_f_r, zeros);
        addSecond(ramp_lo_r, zeros, ramp_s_r, ramp_s_i);
        addFirst(ramp_hi_r, zeros, ramp_f_r, zeros);
        addSecond(zeros, zeros, ramp_s_r, ramp_s_i);
        addIdle();

        resetDut();
        checkOutput("reset_state", 1'b0, 0, 0, 0, 1'b1);

        for (int i = 0; i < tbl.size(); i++) begin
            applyStimulus(tbl[i]);
            checkOutput($sformatf("vec%0d", i), tbl[i].ev, tbl[i].er, tbl[i].ei,
                        tbl[i].eidx, tbl[i].cd);
        end

        // Asynchronous reset in the middle of a block.
        for (int k = 0; k < 4; k++) begin
            v.st = WAITING; v.wn = ZERO; v.vin = 1'b1;
            v.ar = ramp_lo_r[k]; v.ai = 0;
            applyStimulus(v);
        end
        for (int k = 0; k < 2; k++) begin
            v.st = FIRST; v.wn = ZERO; v.vin = 1'b1;
            v.ar = ramp_hi_r[k]; v.ai = 0;
            applyStimulus(v);
        end
        checkOutput("pre_reset", 1'b1, 8, 0, 1, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_reset", 1'b0, 0, 0, 0, 1'b1);
        state = IDLE;
        valid_i = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            v.st = IDLE; v.wn = ZERO; v.vin = 1'b1; v.ar = 5; v.ai = -5;
            applyStimulus(v);
            checkOutput($sformatf("post_reset_idle%0d", k), 1'b0, 0, 0, 0, 1'b1);
        end

        // Randomized controller-like traffic against the reference model.
        resetDut();
        prefilled = 1'b0;
        n = 0;
        for (int b = 0; b < 40; b++) begin
            if (!prefilled || $urandom_range(3) == 0) begin
                for (int g = 0; g < int'($urandom_range(2)); g++) begin
                    randStep(IDLE, 2'($urandom_range(3)), n);
                    n++;
                end
                for (int k = 0; k < 4; k++) begin
                    randStep(WAITING, 2'($urandom_range(3)), n);
                    n++;
                end
            end
            for (int k = 0; k < 4; k++) begin
                randStep(FIRST, 2'($urandom_range(3)), n);
                n++;
            end
            for (int k = 0; k < 4; k++) begin
                randStep(SECOND, 2'($urandom_range(3)), n);
                n++;
            end
            prefilled = 1'b1;
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
